// File: rtl/reset_release_sequencer.sv
// Fabric reset sequencer: qualifies PLL lock and the MSS reset, then releases
// NUM_DOMAINS active-low reset domains one at a time in ascending order.
// Each domain gets a settle delay followed by a ready handshake with timeout.
// A soft request re-sequences a domain and every domain above it.
module reset_release_sequencer #(
    parameter int NUM_DOMAINS        = 4,
    parameter int LOCK_FILTER_CYCLES = 16,
    parameter int STAGE_DELAY        = 32,
    parameter int TIMEOUT_CYCLES     = 1000,
    localparam int CUR_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
    input  logic                   CLK_BASE,
    input  logic                   RESET,
    input  logic                   PLL_LOCK,
    input  logic                   MSS_RESET_N_M2F,
    input  logic [NUM_DOMAINS-1:0] DOMAIN_READY,
    input  logic [NUM_DOMAINS-1:0] SOFT_RESET,
    output logic [NUM_DOMAINS-1:0] DOMAIN_RESET_N,
    output logic                   INIT_DONE,
    output logic                   TIMEOUT_ERR,
    output logic [CUR_W-1:0]       CUR_DOMAIN,
    output logic [2:0]             STATE
);

    localparam int CNT_MAX_A = (LOCK_FILTER_CYCLES > STAGE_DELAY) ? LOCK_FILTER_CYCLES : STAGE_DELAY;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST   = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CUR_W-1:0] LAST_DOMAIN  = CUR_W'(NUM_DOMAINS - 1);

    // SOFT_HOLD is the one-cycle pause after a soft request; it reports as STAGE.
    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STAGE     = 3'd1,
        ACK       = 3'd2,
        DONE      = 3'd3,
        FAULT     = 3'd4,
        SOFT_HOLD = 3'd5
    } state_t;

    state_t                   state_q, state_nxt;
    logic [CNT_W-1:0]         cnt_q, cnt_nxt;
    logic [CUR_W-1:0]         cur_q, cur_nxt;
    logic [CUR_W-1:0]         soft_k_q, soft_k_nxt;
    logic [CUR_W-1:0]         soft_k_sel;
    logic [NUM_DOMAINS-1:0]   dom_q, dom_nxt;
    logic                     init_q, init_nxt;
    logic                     terr_q, terr_nxt;

    logic                     lock_p0, lock_p1;
    logic                     mss_p0, mss_p1;
    logic [NUM_DOMAINS-1:0]   ready_gate;
    logic [NUM_DOMAINS-1:0]   rdy_p0, rdy_p1;
    logic                     lock_ok;

    // A domain's ready is only sampled once its settle delay has elapsed, so a
    // stale ready left over from before the release can never acknowledge it.
    always_comb begin
        ready_gate = '0;
        if (state_q == ACK) begin
            ready_gate[cur_q] = DOMAIN_READY[cur_q];
        end
    end

    // Two-flop synchronisers for the asynchronous qualifiers and ready acks.
    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            lock_p0 <= 1'b0;
            lock_p1 <= 1'b0;
            mss_p0  <= 1'b0;
            mss_p1  <= 1'b0;
            rdy_p0  <= '0;
            rdy_p1  <= '0;
        end else begin
            lock_p0 <= PLL_LOCK;
            lock_p1 <= lock_p0;
            mss_p0  <= MSS_RESET_N_M2F;
            mss_p1  <= mss_p0;
            rdy_p0  <= ready_gate;
            rdy_p1  <= rdy_p0;
        end
    end

    assign lock_ok = lock_p1 & mss_p1;

    // Lowest requested soft-reset domain; everything at or above it restarts.
    always_comb begin
        soft_k_sel = '0;
        for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
            if (SOFT_RESET[i]) begin
                soft_k_sel = CUR_W'(i);
            end
        end
    end

    // Next-state and output decode; lock loss outranks soft requests and acks.
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        cur_nxt    = cur_q;
        soft_k_nxt = soft_k_q;
        dom_nxt    = dom_q;
        terr_nxt   = terr_q;

        if (!lock_ok && (state_q inside {STAGE, SOFT_HOLD, ACK, DONE})) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
            cur_nxt   = '0;
            dom_nxt   = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    dom_nxt = '0;
                    if (!lock_ok) begin
                        cnt_nxt = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_nxt  = STAGE;
                        cnt_nxt    = '0;
                        cur_nxt    = '0;
                        dom_nxt[0] = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
                STAGE: begin
                    if (cnt_q == STAGE_LAST) begin
                        state_nxt = ACK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
                SOFT_HOLD: begin
                    state_nxt         = STAGE;
                    cnt_nxt           = '0;
                    cur_nxt           = soft_k_q;
                    dom_nxt[soft_k_q] = 1'b1;
                end
                ACK: begin
                    if (rdy_p1[cur_q]) begin
                        cnt_nxt = '0;
                        if (cur_q == LAST_DOMAIN) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt        = STAGE;
                            cur_nxt          = cur_q + 1'b1;
                            dom_nxt[cur_nxt] = 1'b1;
                        end
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_nxt      = FAULT;
                        cnt_nxt        = '0;
                        terr_nxt       = 1'b1;
                        dom_nxt[cur_q] = 1'b0;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (SOFT_RESET != '0) begin
                        state_nxt  = SOFT_HOLD;
                        cnt_nxt    = '0;
                        soft_k_nxt = soft_k_sel;
                        for (int i = 0; i < NUM_DOMAINS; i++) begin
                            if (CUR_W'(i) >= soft_k_sel) begin
                                dom_nxt[i] = 1'b0;
                            end
                        end
                    end
                end
                FAULT: begin
                    terr_nxt = 1'b1;
                end
                default: begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                    cur_nxt   = '0;
                    dom_nxt   = '0;
                end
            endcase
        end

        init_nxt = (state_nxt == DONE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            cur_q    <= '0;
            soft_k_q <= '0;
            dom_q    <= '0;
            init_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            cur_q    <= cur_nxt;
            soft_k_q <= soft_k_nxt;
            dom_q    <= dom_nxt;
            init_q   <= init_nxt;
            terr_q   <= terr_nxt;
        end
    end

    assign DOMAIN_RESET_N = dom_q;
    assign INIT_DONE      = init_q;
    assign TIMEOUT_ERR    = terr_q;
    assign CUR_DOMAIN     = cur_q;
    assign STATE          = (state_q == SOFT_HOLD) ? STAGE : state_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer at default parameters.
module tb_reset_release_sequencer;

    logic       CLK_BASE = 1'b0;
    logic       RESET;
    logic       PLL_LOCK;
    logic       MSS_RESET_N_M2F;
    logic [3:0] DOMAIN_READY;
    logic [3:0] SOFT_RESET;
    logic [3:0] DOMAIN_RESET_N;
    logic       INIT_DONE;
    logic       TIMEOUT_ERR;
    logic [1:0] CUR_DOMAIN;
    logic [2:0] STATE;

    int n_checks = 0;
    int n_fail   = 0;
    int edges    = 0;

    always #5 CLK_BASE = ~CLK_BASE;

    reset_release_sequencer dut (
        .CLK_BASE        (CLK_BASE),
        .RESET           (RESET),
        .PLL_LOCK        (PLL_LOCK),
        .MSS_RESET_N_M2F (MSS_RESET_N_M2F),
        .DOMAIN_READY    (DOMAIN_READY),
        .SOFT_RESET      (SOFT_RESET),
        .DOMAIN_RESET_N  (DOMAIN_RESET_N),
        .INIT_DONE       (INIT_DONE),
        .TIMEOUT_ERR     (TIMEOUT_ERR),
        .CUR_DOMAIN      (CUR_DOMAIN),
        .STATE           (STATE)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the falling edge that follows rising edge number e since release.
    task automatic goto_edge(input int e);
        while (edges < e) begin
            @(negedge CLK_BASE);
            edges++;
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_dom"},   32'(DOMAIN_RESET_N), 32'h0);
        check({pfx, "_init"},  32'(INIT_DONE),      32'h0);
        check({pfx, "_terr"},  32'(TIMEOUT_ERR),    32'h0);
        check({pfx, "_cur"},   32'(CUR_DOMAIN),     32'h0);
        check({pfx, "_state"}, 32'(STATE),          32'h0);
    endtask

    initial begin
        RESET           = 1'b1;
        PLL_LOCK        = 1'b1;
        MSS_RESET_N_M2F = 1'b1;
        DOMAIN_READY    = 4'hF;
        SOFT_RESET      = 4'h0;
        repeat (3) @(negedge CLK_BASE);
        check_reset_values("rst");

        // Nominal power-up sequence.
        RESET = 1'b0;
        edges = 0;
        goto_edge(17);  check("d0_before",  32'(DOMAIN_RESET_N), 32'h0);
        goto_edge(18);  check("d0_rise",    32'(DOMAIN_RESET_N), 32'h1);
                        check("d0_state",   32'(STATE),          32'h1);
        goto_edge(52);  check("d1_before",  32'(DOMAIN_RESET_N), 32'h1);
        goto_edge(53);  check("d1_rise",    32'(DOMAIN_RESET_N), 32'h3);
                        check("d1_cur",     32'(CUR_DOMAIN),     32'h1);
        goto_edge(87);  check("d2_before",  32'(DOMAIN_RESET_N), 32'h3);
        goto_edge(88);  check("d2_rise",    32'(DOMAIN_RESET_N), 32'h7);
        goto_edge(122); check("d3_before",  32'(DOMAIN_RESET_N), 32'h7);
        goto_edge(123); check("d3_rise",    32'(DOMAIN_RESET_N), 32'hF);
        goto_edge(157); check("done_before",32'(INIT_DONE),      32'h0);
                        check("ack3_state", 32'(STATE),          32'h2);
        goto_edge(158); check("done_init",  32'(INIT_DONE),      32'h1);
                        check("done_state", 32'(STATE),          32'h3);
                        check("done_cur",   32'(CUR_DOMAIN),     32'h3);

        // Soft re-sequence from domain 1.
        goto_edge(200);
        SOFT_RESET = 4'b0110;
        goto_edge(201);
        SOFT_RESET = 4'b0000;
        check("soft_dom",    32'(DOMAIN_RESET_N), 32'h1);
        check("soft_init",   32'(INIT_DONE),      32'h0);
        check("soft_state",  32'(STATE),          32'h1);
        goto_edge(202); check("soft_d1",     32'(DOMAIN_RESET_N), 32'h3);
                        check("soft_cur",    32'(CUR_DOMAIN),     32'h1);
        goto_edge(236); check("soft_d2_pre", 32'(DOMAIN_RESET_N), 32'h3);
        goto_edge(237); check("soft_d2",     32'(DOMAIN_RESET_N), 32'h7);
        goto_edge(272); check("soft_d3",     32'(DOMAIN_RESET_N), 32'hF);
        goto_edge(306); check("soft_done_pre", 32'(INIT_DONE),    32'h0);
        goto_edge(307); check("soft_done",   32'(INIT_DONE),      32'h1);

        // Lock loss while done, then recovery.
        goto_edge(320);
        PLL_LOCK = 1'b0;
        goto_edge(322); check("ll_hold",   32'(DOMAIN_RESET_N), 32'hF);
        goto_edge(323); check("ll_dom",    32'(DOMAIN_RESET_N), 32'h0);
                        check("ll_init",   32'(INIT_DONE),      32'h0);
                        check("ll_state",  32'(STATE),          32'h0);
        goto_edge(330);
        PLL_LOCK = 1'b1;
        goto_edge(347); check("rl_d0_pre", 32'(DOMAIN_RESET_N), 32'h0);
        goto_edge(348); check("rl_d0",     32'(DOMAIN_RESET_N), 32'h1);
        goto_edge(383); check("rl_d1",     32'(DOMAIN_RESET_N), 32'h3);

        // Asynchronous reset during the ack of domain 1.
        goto_edge(416); check("ack1_state", 32'(STATE),      32'h2);
                        check("ack1_cur",   32'(CUR_DOMAIN), 32'h1);
        RESET = 1'b1;
        #1;
        check_reset_values("async_rst");
        repeat (2) @(negedge CLK_BASE);

        // Glitchy lock never satisfies the filter.
        PLL_LOCK = 1'b1;
        RESET    = 1'b0;
        edges    = 0;
        for (int c = 0; c < 120; c++) begin
            PLL_LOCK = ((edges % 10) == 9) ? 1'b0 : 1'b1;
            goto_edge(edges + 1);
            if ((edges % 40) == 0) begin
                check("glitch_dom",   32'(DOMAIN_RESET_N), 32'h0);
                check("glitch_state", 32'(STATE),          32'h0);
            end
        end

        // Domain 2 never acknowledges.
        RESET        = 1'b1;
        PLL_LOCK     = 1'b1;
        DOMAIN_READY = 4'b1011;
        repeat (2) @(negedge CLK_BASE);
        RESET = 1'b0;
        edges = 0;
        goto_edge(88);   check("to_d2",        32'(DOMAIN_RESET_N), 32'h7);
        goto_edge(1119); check("to_pre_state", 32'(STATE),          32'h2);
                         check("to_pre_terr",  32'(TIMEOUT_ERR),    32'h0);
        goto_edge(1120); check("to_terr",      32'(TIMEOUT_ERR),    32'h1);
                         check("to_state",     32'(STATE),          32'h4);
                         check("to_cur",       32'(CUR_DOMAIN),     32'h2);
                         check("to_dom",       32'(DOMAIN_RESET_N), 32'h3);
                         check("to_init",      32'(INIT_DONE),      32'h0);
        PLL_LOCK = 1'b0;
        goto_edge(1130); check("flt_ll_state", 32'(STATE),          32'h4);
                         check("flt_ll_dom",   32'(DOMAIN_RESET_N), 32'h3);
                         check("flt_ll_terr",  32'(TIMEOUT_ERR),    32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_release_sequencer.md
Name: reset_release_sequencer

Overview:
- Parametrised fabric reset sequencer that replaces the fixed single-domain reset bridge in the MSS subsystem.
- Qualifies CCC PLL lock and the MSS reset, then releases NUM_DOMAINS fabric reset domains one at a time in index order.
- Each release waits a settle time and a per-domain ready acknowledge, with timeout fault detection.
- Supports soft re-sequencing of any domain and all domains above it.

Parameters:
- NUM_DOMAINS, 4, number of sequenced reset domains (1..16).
- LOCK_FILTER_CYCLES, 16, consecutive synchronised-lock cycles required before release.
- STAGE_DELAY, 32, cycles between releasing a domain and starting to sample its ready (>=1).
- TIMEOUT_CYCLES, 1000, maximum ACK wait per domain before fault (>=1).

Ports:
- CLK_BASE  in  1  fabric clock (CCC GL0).
- RESET  in  1  asynchronous, active-high reset.
- PLL_LOCK  in  1  CCC lock; asynchronous; 2-flop synchronised internally.
- MSS_RESET_N_M2F  in  1  MSS reset, active-low; asynchronous; 2-flop synchronised.
- DOMAIN_READY  in  NUM_DOMAINS  per-domain ready ack; 2-flop synchronised.
- SOFT_RESET  in  NUM_DOMAINS  per-domain re-sequence request; synchronous to CLK_BASE; honoured only in DONE.
- DOMAIN_RESET_N  out  NUM_DOMAINS  per-domain active-low reset; registered.
- INIT_DONE  out  1  all domains released and acknowledged.
- TIMEOUT_ERR  out  1  sticky fault flag.
- CUR_DOMAIN  out  clog2(NUM_DOMAINS) (min 1)  domain being sequenced, or the faulting domain.
- STATE  out  3  state encoding for debug.

Behaviour:
- Reset values while RESET=1: DOMAIN_RESET_N=all 0, INIT_DONE=0, TIMEOUT_ERR=0, CUR_DOMAIN=0, STATE=WAIT_LOCK (0).
- All synchronisers clear to 0 on RESET.
- "lock_ok" = synced PLL_LOCK AND synced MSS_RESET_N_M2F.
- Single counter; width clog2(max(LOCK_FILTER_CYCLES, STAGE_DELAY, TIMEOUT_CYCLES)+1).
- Counter clears on every state transition.
- States:
  - WAIT_LOCK(0): all DOMAIN_RESET_N=0.
    - Counter increments each cycle lock_ok=1 and clears when lock_ok=0.
    - When counter reaches LOCK_FILTER_CYCLES-1 with lock_ok=1: go to STAGE, CUR_DOMAIN=0, DOMAIN_RESET_N[0]=1 on the same edge.
  - STAGE(1): count STAGE_DELAY cycles, then go to ACK.
  - ACK(2):
    - Synced DOMAIN_READY[CUR_DOMAIN]=1: if CUR_DOMAIN=NUM_DOMAINS-1, go to DONE; else increment CUR_DOMAIN, release that domain on the same edge, go to STAGE.
    - Ready low for TIMEOUT_CYCLES cycles: go to FAULT.
  - DONE(3): INIT_DONE=1, CUR_DOMAIN holds NUM_DOMAINS-1.
    - On SOFT_RESET≠0, let k = lowest set bit:
      - Edge 1: assert DOMAIN_RESET_N[k..N-1]=0, INIT_DONE=0, state WAIT_LOCK-bypass hold (stays in STAGE with reset asserted) for one cycle.
      - Next edge: CUR_DOMAIN=k, release domain k, STAGE.
      - Domains below k stay released.
  - FAULT(4): TIMEOUT_ERR=1, INIT_DONE=0, CUR_DOMAIN frozen at the failing domain.
    - Domains already released stay released; the failing domain and all above it are 0.
    - Exit only via RESET.
- Lock loss: lock_ok=0 in STAGE, ACK or DONE asserts all DOMAIN_RESET_N=0 and drops INIT_DONE on the next edge, then goes to WAIT_LOCK. FAULT ignores lock loss.
- Priority in one cycle: RESET > lock loss > SOFT_RESET > ready/timeout.
- Release order is strictly ascending; at most one domain changes 0→1 per edge.
- Input-to-state latency: 2 cycles of synchroniser delay on PLL_LOCK, MSS_RESET_N_M2F and DOMAIN_READY.
- RESET mid-sequence returns immediately (asynchronously) to reset values. Sequencing restarts from domain 0 after RESET falls.
- NUM_DOMAINS=1: CUR_DOMAIN is 1 bit, always 0.

Test Plan:
- Defaults, PLL_LOCK and MSS_RESET_N_M2F high from cycle 0, DOMAIN_READY=4'hF -> DOMAIN_RESET_N[0] rises 18 cycles after RESET falls; bits 1,2,3 rise at 35-cycle spacing (STAGE_DELAY+3 sync/ACK cycles); INIT_DONE=1 after bit 3's ACK; STATE=3.
- PLL_LOCK toggled low for 1 cycle every 10 cycles -> filter never completes; DOMAIN_RESET_N stays 4'h0 and STATE=0 indefinitely.
- DOMAIN_READY[2] held 0 -> after domain 2's STAGE, TIMEOUT_ERR=1 after 1000 ACK cycles; STATE=4, CUR_DOMAIN=2, DOMAIN_RESET_N=4'b0011; later PLL_LOCK drop changes nothing.
- In DONE, pulse SOFT_RESET=4'b0110 for 1 cycle -> DOMAIN_RESET_N goes to 4'b0001 and INIT_DONE=0; domains 1,2,3 re-release in order; INIT_DONE returns to 1.
- In DONE, drop PLL_LOCK -> DOMAIN_RESET_N=4'h0 and INIT_DONE=0 within 3 cycles; full re-sequence after lock returns.
- Assert RESET during ACK of domain 1 -> all outputs return to reset values immediately without a clock edge.
